// File: rtl/exec_unit_muldiv_pkg.sv
// Shared types for the exec unit with M-extension multiply/divide support.
// Operation codes, operand selects, the request params struct and FSM states.
package exec_unit_muldiv_pkg;

    typedef enum logic {
        OP1_RS1 = 1'b0,
        OP1_PC  = 1'b1
    } op1_sel_e;

    typedef enum logic {
        OP2_RS2 = 1'b0,
        OP2_IMM = 1'b1
    } op2_sel_e;

    // Base ALU codes occupy 0..9; the M-extension codes sit at 16..23.
    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } exec_op_e;

    typedef struct packed {
        op1_sel_e operand1_sel;
        op2_sel_e operand2_sel;
        exec_op_e exec_op;
    } exec_muldiv_params;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } exec_state_e;

    function automatic logic is_mul_op(input exec_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_div_op(input exec_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem_op(input exec_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_div(input exec_op_e op);
        return op inside {OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/exec_unit_muldiv_div.sv
// Radix-2 restoring divider: one quotient bit per clock over XLEN iterations.
// o_done flags the cycle whose edge performs the final step; results are valid then.
module exec_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_signed,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_done,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder
);

    localparam int CNT_W = $clog2(XLEN);

    logic              r_active;
    logic [CNT_W-1:0]  r_count;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_divisor;
    logic              r_neg_q;
    logic              r_neg_r;

    logic              w_dividend_neg;
    logic              w_divisor_neg;
    logic [XLEN-1:0]   w_abs_dividend;
    logic [XLEN-1:0]   w_abs_divisor;
    logic [XLEN:0]     w_rem_shift;
    logic [XLEN:0]     w_diff;
    logic              w_q_bit;
    logic [XLEN-1:0]   w_rem_next;
    logic [XLEN-1:0]   w_quo_next;

    assign w_dividend_neg = i_signed && i_dividend[XLEN-1];
    assign w_divisor_neg  = i_signed && i_divisor[XLEN-1];
    assign w_abs_dividend = w_dividend_neg ? -i_dividend : i_dividend;
    assign w_abs_divisor  = w_divisor_neg ? -i_divisor : i_divisor;

    // The dividend shifts out of the quotient register while quotient bits shift in.
    assign w_rem_shift = {r_rem, r_quo[XLEN-1]};
    assign w_diff      = w_rem_shift - {1'b0, r_divisor};
    assign w_q_bit     = ~w_diff[XLEN];
    assign w_rem_next  = w_q_bit ? w_diff[XLEN-1:0] : w_rem_shift[XLEN-1:0];
    assign w_quo_next  = {r_quo[XLEN-2:0], w_q_bit};

    assign o_done      = r_active && (r_count == CNT_W'(XLEN - 1));
    assign o_quotient  = r_neg_q ? -w_quo_next : w_quo_next;
    assign o_remainder = r_neg_r ? -w_rem_next : w_rem_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active  <= 1'b0;
            r_count   <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else if (i_start) begin
            r_active  <= 1'b1;
            r_count   <= '0;
            r_quo     <= w_abs_dividend;
            r_rem     <= '0;
            r_divisor <= w_abs_divisor;
            r_neg_q   <= w_dividend_neg ^ w_divisor_neg;
            r_neg_r   <= w_dividend_neg;
        end else if (r_active) begin
            r_quo   <= w_quo_next;
            r_rem   <= w_rem_next;
            r_count <= r_count + CNT_W'(1);
            if (o_done) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_unit_muldiv.sv
// Exec unit with base ALU plus M-extension multiply and iterative divide.
// Single outstanding request; the result is held until the consumer takes it.
module exec_unit_muldiv
    import exec_unit_muldiv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic [XLEN-1:0]   imm_val,
    input  exec_muldiv_params params,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   exec_out,
    output logic              busy
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    exec_state_e       r_state;
    exec_state_e       w_next_state;
    exec_op_e          r_op;
    logic [XLEN-1:0]   r_op1;
    logic [XLEN-1:0]   r_op2;
    logic              r_div_zero;
    logic [XLEN-1:0]   r_exec_out;

    logic              w_accept;
    logic [XLEN-1:0]   w_op1;
    logic [XLEN-1:0]   w_op2;
    logic [SHAMT_W-1:0] w_shamt;
    logic [XLEN-1:0]   w_alu_result;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_div_special;
    logic              w_div_start;
    logic              w_div_signed;
    logic              w_div_done;
    logic [XLEN-1:0]   w_div_quo;
    logic [XLEN-1:0]   w_div_rem;
    logic              w_mul_a_signed;
    logic              w_mul_b_signed;
    logic [2*XLEN-1:0] w_mul_a;
    logic [2*XLEN-1:0] w_mul_b;
    logic [2*XLEN-1:0] w_product;
    logic [XLEN-1:0]   w_mul_result;
    logic [XLEN-1:0]   w_div_special_result;
    logic [XLEN-1:0]   w_stage2_result;

    assign w_accept  = in_valid && (r_state == ST_IDLE);
    assign w_op1     = (params.operand1_sel == OP1_PC)  ? pc      : rs1;
    assign w_op2     = (params.operand2_sel == OP2_IMM) ? imm_val : rs2;
    assign w_shamt   = w_op2[SHAMT_W-1:0];

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign exec_out  = r_exec_out;

    // Single-cycle ALU evaluated on live operands; unknown codes fall through to ADD.
    always_comb begin
        w_alu_result = w_op1 + w_op2;
        case (params.exec_op)
            OP_SUB:  w_alu_result = w_op1 - w_op2;
            OP_SLL:  w_alu_result = w_op1 << w_shamt;
            OP_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, $signed(w_op1) < $signed(w_op2)};
            OP_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, w_op1 < w_op2};
            OP_XOR:  w_alu_result = w_op1 ^ w_op2;
            OP_SRL:  w_alu_result = w_op1 >> w_shamt;
            OP_SRA:  w_alu_result = $signed(w_op1) >>> w_shamt;
            OP_OR:   w_alu_result = w_op1 | w_op2;
            OP_AND:  w_alu_result = w_op1 & w_op2;
            default: ;
        endcase
    end

    // Corner cases are resolved at acceptance so they skip the iterative divider.
    assign w_div_signed  = is_signed_div(params.exec_op);
    assign w_div_zero    = (w_op2 == '0);
    assign w_div_ovf     = w_div_signed && (w_op1 == MOST_NEG) && (w_op2 == '1);
    assign w_div_special = w_div_zero || w_div_ovf;
    assign w_div_start   = w_accept && is_div_op(params.exec_op) && !w_div_special;

    assign w_mul_a_signed = (r_op == OP_MULH) || (r_op == OP_MULHSU);
    assign w_mul_b_signed = (r_op == OP_MULH);
    assign w_mul_a        = {{XLEN{w_mul_a_signed & r_op1[XLEN-1]}}, r_op1};
    assign w_mul_b        = {{XLEN{w_mul_b_signed & r_op2[XLEN-1]}}, r_op2};
    assign w_product      = w_mul_a * w_mul_b;
    assign w_mul_result   = (r_op == OP_MUL) ? w_product[XLEN-1:0] : w_product[2*XLEN-1:XLEN];

    assign w_div_special_result = r_div_zero ? (is_rem_op(r_op) ? r_op1 : '1)
                                             : (is_rem_op(r_op) ? '0 : r_op1);
    assign w_stage2_result      = is_div_op(r_op) ? w_div_special_result : w_mul_result;

    exec_div_iter #(
        .XLEN(XLEN)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_div_start),
        .i_signed    (w_div_signed),
        .i_dividend  (w_op1),
        .i_divisor   (w_op2),
        .o_done      (w_div_done),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Divide corner cases share the two-cycle multiply path through ST_MUL.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_mul_op(params.exec_op) || (is_div_op(params.exec_op) && w_div_special)) begin
                        w_next_state = ST_MUL;
                    end else if (is_div_op(params.exec_op)) begin
                        w_next_state = ST_DIV;
                    end else begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_MUL:  w_next_state = ST_DONE;
            ST_DIV:  if (w_div_done) w_next_state = ST_DONE;
            ST_DONE: if (out_ready) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= OP_ADD;
            r_op1      <= '0;
            r_op2      <= '0;
            r_div_zero <= 1'b0;
            r_exec_out <= '0;
        end else begin
            if (w_accept) begin
                r_op       <= params.exec_op;
                r_op1      <= w_op1;
                r_op2      <= w_op2;
                r_div_zero <= w_div_zero;
                if (w_next_state == ST_DONE) begin
                    r_exec_out <= w_alu_result;
                end
            end
            if (r_state == ST_MUL) begin
                r_exec_out <= w_stage2_result;
            end
            if ((r_state == ST_DIV) && w_div_done) begin
                r_exec_out <= is_rem_op(r_op) ? w_div_rem : w_div_quo;
            end
        end
    end

endmodule

// File: tb/tb_exec_unit_muldiv.sv
// Scoreboard bench for exec_unit_muldiv: directed corner cases plus random ops
// checked against an arithmetic reference model, with result latency and stalls.
module tb_exec_unit_muldiv;
    import exec_unit_muldiv_pkg::*;

    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   imm_val;
    exec_muldiv_params params;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [XLEN-1:0]   exec_out;
    logic              busy;

    typedef struct {
        logic [31:0] result;
        int          lat;
        int          acceptCyc;
        int          stall;
        string       name;
    } exp_t;

    exp_t expq[$];
    exp_t cur;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   stallLeft = 0;
    logic haveItem = 1'b0;
    logic expectIdle = 1'b0;
    logic busyDrop = 1'b0;

    logic [4:0] opList [18] = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
                                OP_OR, OP_AND, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                                OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    exec_unit_muldiv #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pc        (pc),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm_val   (imm_val),
        .params    (params),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exec_out  (exec_out),
        .busy      (busy)
    );

    // Free-running clock and edge counter used to measure result latency.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference behaviour straight from the ISA rules using wide integer arithmetic.
    function automatic void refModel(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] res, output int lat);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] prod;
        logic [4:0]  sh;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        sh  = b[4:0];
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        lat = 1;
        res = a + b;
        case (op)
            OP_SUB:    res = a - b;
            OP_SLL:    res = a << sh;
            OP_SLT:    res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU:   res = (a < b) ? 32'd1 : 32'd0;
            OP_XOR:    res = a ^ b;
            OP_SRL:    res = a >> sh;
            OP_SRA:    res = 32'($signed(a) >>> sh);
            OP_OR:     res = a | b;
            OP_AND:    res = a & b;
            OP_MUL:    begin prod = sa * sb; res = prod[31:0];  lat = 2; end
            OP_MULH:   begin prod = sa * sb; res = prod[63:32]; lat = 2; end
            OP_MULHSU: begin prod = sa * ub; res = prod[63:32]; lat = 2; end
            OP_MULHU:  begin prod = ua * ub; res = prod[63:32]; lat = 2; end
            OP_DIV: begin
                if (b == 0) begin res = 32'hFFFF_FFFF; lat = 2; end
                else if (ovf) begin res = a; lat = 2; end
                else begin res = 32'($signed(a) / $signed(b)); lat = 33; end
            end
            OP_DIVU: begin
                if (b == 0) begin res = 32'hFFFF_FFFF; lat = 2; end
                else begin res = a / b; lat = 33; end
            end
            OP_REM: begin
                if (b == 0) begin res = a; lat = 2; end
                else if (ovf) begin res = 32'd0; lat = 2; end
                else begin res = 32'($signed(a) % $signed(b)); lat = 33; end
            end
            OP_REMU: begin
                if (b == 0) begin res = a; lat = 2; end
                else begin res = a % b; lat = 33; end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Present one request, wait for acceptance, record the expected response,
    // then scramble the inputs so late changes would corrupt a non-capturing DUT.
    task automatic applyStimulus(input string name, input logic [4:0] op, input logic s1, input logic s2,
                                 input logic [31:0] aRs1, input logic [31:0] aRs2,
                                 input logic [31:0] aPc, input logic [31:0] aImm, input int stall);
        int          waitCnt;
        exp_t        it;
        logic [31:0] opA;
        logic [31:0] opB;
        @(negedge clk);
        rs1 = aRs1; rs2 = aRs2; pc = aPc; imm_val = aImm;
        params.operand1_sel = op1_sel_e'(s1);
        params.operand2_sel = op2_sel_e'(s2);
        params.exec_op      = exec_op_e'(op);
        in_valid = 1'b1;
        waitCnt = 0;
        while (!in_ready && waitCnt < 300) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) begin
            checkOutput({name, "_accept_timeout"}, in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        opA = s1 ? aPc : aRs1;
        opB = s2 ? aImm : aRs2;
        refModel(op, opA, opB, it.result, it.lat);
        it.acceptCyc = cyc + 1;
        it.stall     = stall;
        it.name      = name;
        expq.push_back(it);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rs1 = $urandom; rs2 = $urandom; pc = $urandom; imm_val = $urandom;
        params.exec_op = exec_op_e'(5'($urandom_range(0, 23)));
    endtask

    // Monitor: pops the scoreboard on each new result, checks value, latency,
    // hold-while-stalled behaviour and the return of in_ready after the handshake.
    always @(negedge clk) begin
        if (rst) begin
            haveItem   = 1'b0;
            expectIdle = 1'b0;
            out_ready  = 1'b0;
        end else begin
            if (expectIdle) begin
                expectIdle = 1'b0;
                checkOutput({cur.name, "_ready_after_hs"}, in_ready, 1);
                checkOutput({cur.name, "_valid_after_hs"}, out_valid, 0);
            end
            if (out_valid) begin
                if (!haveItem) begin
                    if (expq.size() == 0) begin
                        checkOutput("unexpected_out_valid", out_valid, 0);
                    end else begin
                        cur = expq.pop_front();
                        checkOutput({cur.name, "_result"}, exec_out, cur.result);
                        checkOutput({cur.name, "_latency"}, 64'(cyc - cur.acceptCyc + 1), 64'(cur.lat));
                        checkOutput({cur.name, "_busy_pending"}, busyDrop, 0);
                        busyDrop  = 1'b0;
                        haveItem  = 1'b1;
                        stallLeft = cur.stall;
                    end
                end else begin
                    checkOutput({cur.name, "_stable"}, exec_out, cur.result);
                    checkOutput({cur.name, "_ready_in_stall"}, in_ready, 0);
                    checkOutput({cur.name, "_busy_in_done"}, busy, 1);
                end
                if (haveItem) begin
                    if (stallLeft == 0) begin
                        out_ready  = 1'b1;
                        haveItem   = 1'b0;
                        expectIdle = 1'b1;
                    end else begin
                        out_ready = 1'b0;
                        stallLeft--;
                    end
                end
            end else begin
                out_ready = 1'b0;
                if (expq.size() > 0 && cyc >= expq[0].acceptCyc && !busy) begin
                    busyDrop = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        pc = '0; rs1 = '0; rs2 = '0; imm_val = '0;
        params.operand1_sel = OP1_RS1;
        params.operand2_sel = OP2_RS2;
        params.exec_op      = OP_ADD;
        repeat (3) @(negedge clk);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_exec_out", exec_out, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", in_ready, 1);

        applyStimulus("add_5_7",      OP_ADD,  0, 0, 32'd5, 32'd7, 32'd0, 32'd0, 0);
        applyStimulus("mulh_min",     OP_MULH, 0, 0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 0);
        applyStimulus("mul_min",      OP_MUL,  0, 0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 0);
        applyStimulus("div_m7_2",     OP_DIV,  0, 0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 0);
        applyStimulus("rem_m7_2",     OP_REM,  0, 0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 0);
        applyStimulus("divu_10_0",    OP_DIVU, 0, 0, 32'd10, 32'd0, 32'd0, 32'd0, 0);
        applyStimulus("rem_10_0",     OP_REM,  0, 0, 32'd10, 32'd0, 32'd0, 32'd0, 0);
        applyStimulus("div_ovf",      OP_DIV,  0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 0);
        applyStimulus("stall5_xor",   OP_XOR,  0, 0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 32'd0, 5);
        applyStimulus("pc_plus_imm",  OP_ADD,  1, 1, 32'd99, 32'd99, 32'h0000_1000, 32'h20, 0);
        applyStimulus("sra_imm",      OP_SRA,  0, 1, 32'h8000_00F0, 32'd0, 32'd0, 32'd36, 0);
        applyStimulus("unknown_op",   5'd12,   0, 0, 32'd40, 32'd2, 32'd0, 32'd0, 0);
        applyStimulus("mulhsu_stall", OP_MULHSU, 0, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd0, 2);

        for (int n = 0; n < 60; n++) begin
            logic [4:0] op;
            int         k;
            k  = $urandom_range(0, 18);
            op = (k == 18) ? 5'(10 + $urandom_range(0, 5)) : opList[k];
            applyStimulus($sformatf("rand%0d_op%0d", n, op), op, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), randOperand(), randOperand(), randOperand(),
                          randOperand(), $urandom_range(0, 2));
        end

        for (int i = 0; i < 300 && (expq.size() > 0 || haveItem || expectIdle); i++) @(negedge clk);
        checkOutput("drain_before_abort", (expq.size() > 0) || haveItem, 0);

        applyStimulus("div_abort", OP_DIV, 0, 0, 32'd100, 32'd7, 32'd0, 32'd0, 0);
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_busy", busy, 0);
        expq.delete();
        busyDrop = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_abort", in_ready, 1);
        checkOutput("no_result_after_abort", out_valid, 0);
        applyStimulus("add_after_abort", OP_ADD, 0, 0, 32'd5, 32'd7, 32'd0, 32'd0, 0);

        for (int i = 0; i < 300 && (expq.size() > 0 || haveItem || expectIdle); i++) @(negedge clk);
        checkOutput("drain_final", (expq.size() > 0) || haveItem, 0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
